// File: rtl/sa_result_drain.sv
// Result capture and drain engine for the systolic array: times a run from start to
// comp_done, snapshots the M x K result bus, then streams it row-major over valid/ready.
module sa_result_drain #(
    parameter int M       = 2,
    parameter int K       = 2,
    parameter int DW      = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096,
    localparam int RW     = ($clog2(M) > 0) ? $clog2(M) : 1,
    localparam int CW     = ($clog2(K) > 0) ? $clog2(K) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              comp_done,
    input  logic              arr_error,
    input  logic [M*K*DW-1:0] res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_flags
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [RW-1:0]    ROW_MAX = RW'(M - 1);
    localparam logic [CW-1:0]    COL_MAX = CW'(K - 1);

    state_t              state_q, state_d;
    logic [M*K*DW-1:0]   buf_q, buf_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          err_q, err_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                at_last;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            buf_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                err_d[0] = err_q[0] | arr_error;
                err_d[2] = err_q[2] | start;
                cnt_d    = cnt_inc;
                // comp_done wins over a timeout landing on the same edge
                if (comp_done) begin
                    buf_d   = res_in;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DRAIN;
                end else if (cnt_inc == TO_CNT) begin
                    err_d[1] = 1'b1;
                    state_d  = DONE;
                end
            end
            DRAIN: begin
                err_d[0] = err_q[0] | arr_error;
                err_d[2] = err_q[2] | start;
                if (out_ready) begin
                    // element 0 of the buffer is always the one on the bus
                    buf_d = buf_q >> DW;
                    if (at_last) begin
                        state_d = DONE;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid   = (state_q == DRAIN);
    assign out_data    = out_valid ? buf_q[DW-1:0] : '0;
    assign out_row     = out_valid ? row_q : '0;
    assign out_col     = out_valid ? col_q : '0;
    assign out_last    = out_valid && at_last;
    assign cycle_count = cnt_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign err_flags   = err_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: 2x2 default, 2x2 with short timeout, and 3x4 instances.
`timescale 1ns/1ps
module tb_sa_result_drain;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // instance A: 2x2, default timeout
    logic        start_a = 0, comp_a = 0, aerr_a = 0, rdy_a = 0;
    logic [127:0] res_a;
    logic        vld_a, last_a, busy_a, done_a;
    logic [31:0] data_a, cnt_a;
    logic        row_a, col_a;
    logic [2:0]  err_a;

    // instance B: 2x2, TIMEOUT=16
    logic        start_b = 0, comp_b = 0, aerr_b = 0, rdy_b = 1;
    logic [127:0] res_b = '0;
    logic        vld_b, last_b, busy_b, done_b;
    logic [31:0] data_b, cnt_b;
    logic        row_b, col_b;
    logic [2:0]  err_b;

    // instance C: 3x4
    logic        start_c = 0, comp_c = 0, aerr_c = 0, rdy_c = 0;
    logic [383:0] res_c;
    logic        vld_c, last_c, busy_c, done_c;
    logic [31:0] data_c, cnt_c;
    logic [1:0]  row_c, col_c;
    logic [2:0]  err_c;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_a [4];

    sa_result_drain #(.M(2), .K(2), .DW(32), .CNT_W(32), .TIMEOUT(4096)) u_a (
        .CLK(CLK), .RST(RST), .start(start_a), .comp_done(comp_a), .arr_error(aerr_a),
        .res_in(res_a), .out_valid(vld_a), .out_ready(rdy_a), .out_data(data_a),
        .out_row(row_a), .out_col(col_a), .out_last(last_a), .cycle_count(cnt_a),
        .busy(busy_a), .done(done_a), .err_flags(err_a));

    sa_result_drain #(.M(2), .K(2), .DW(32), .CNT_W(32), .TIMEOUT(16)) u_b (
        .CLK(CLK), .RST(RST), .start(start_b), .comp_done(comp_b), .arr_error(aerr_b),
        .res_in(res_b), .out_valid(vld_b), .out_ready(rdy_b), .out_data(data_b),
        .out_row(row_b), .out_col(col_b), .out_last(last_b), .cycle_count(cnt_b),
        .busy(busy_b), .done(done_b), .err_flags(err_b));

    sa_result_drain #(.M(3), .K(4), .DW(32), .CNT_W(32), .TIMEOUT(4096)) u_c (
        .CLK(CLK), .RST(RST), .start(start_c), .comp_done(comp_c), .arr_error(aerr_c),
        .res_in(res_c), .out_valid(vld_c), .out_ready(rdy_c), .out_data(data_c),
        .out_row(row_c), .out_col(col_c), .out_last(last_c), .cycle_count(cnt_c),
        .busy(busy_c), .done(done_c), .err_flags(err_c));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // pulse start, then raise comp_done on the lat-th edge after the start edge
    task automatic run_a(input int lat);
        start_a = 1; step(); start_a = 0;
        repeat (lat - 1) step();
        comp_a = 1; step(); comp_a = 0;
    endtask

    task automatic drain_a(input int first, input int n);
        rdy_a = 1;
        for (int b = first; b < first + n; b++) begin
            n_cmp++;
            if ({vld_a, row_a, col_a, last_a, data_a} !== {1'b1, 1'(b / 2), 1'(b % 2), (b == 3), exp_a[b]}) begin
                n_fail++;
                $display("FAIL drain_a beat %0d: got v=%b r=%b c=%b l=%b d=%h, want r=%0d c=%0d d=%h",
                         b, vld_a, row_a, col_a, last_a, data_a, b / 2, b % 2, exp_a[b]);
            end
            step();
        end
    endtask

    task automatic test_reset();
        RST = 1;
        step(); step();
        n_cmp++;
        if ({vld_a, data_a, row_a, col_a, last_a, cnt_a, busy_a, done_a, err_a} !== '0) begin
            n_fail++;
            $display("FAIL reset: got v=%b d=%h cnt=%0d busy=%b done=%b err=%b, want all 0",
                     vld_a, data_a, cnt_a, busy_a, done_a, err_a);
        end
        RST = 0;
        step();
    endtask

    task automatic test_basic();
        rdy_a = 1;
        run_a(10);
        n_cmp++;
        if ({cnt_a, busy_a} !== {32'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_count: got cnt=%0d busy=%b, want 10 1", cnt_a, busy_a);
        end
        drain_a(0, 4);
        n_cmp++;
        if ({done_a, vld_a, busy_a, err_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 3'b000, 32'd10}) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b v=%b busy=%b err=%b cnt=%0d, want 1 0 0 000 10",
                     done_a, vld_a, busy_a, err_a, cnt_a);
        end
    endtask

    task automatic test_stall();
        int seq [7] = '{1, 0, 0, 1, 0, 1, 1};
        int beats = 0;
        rdy_a = 0;
        run_a(10);
        for (int c = 0; c < 7; c++) begin
            rdy_a = seq[c][0];
            n_cmp++;
            if ({vld_a, row_a, col_a, last_a, data_a} !==
                {1'b1, 1'(beats / 2), 1'(beats % 2), (beats == 3), exp_a[beats]}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got v=%b r=%b c=%b l=%b d=%h, want beat %0d d=%h",
                         c, vld_a, row_a, col_a, last_a, data_a, beats, exp_a[beats]);
            end
            if (seq[c] == 1) beats++;
            step();
        end
        rdy_a = 1;
        n_cmp++;
        if ({beats, done_a, vld_a} !== {32'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_done: got beats=%0d done=%b v=%b, want 4 1 0", beats, done_a, vld_a);
        end
    endtask

    task automatic test_timeout();
        logic saw_valid = 0;
        start_b = 1; step(); start_b = 0;
        repeat (15) begin
            saw_valid |= vld_b;
            step();
        end
        n_cmp++;
        if ({done_b, busy_b, cnt_b} !== {1'b0, 1'b1, 32'd15}) begin
            n_fail++;
            $display("FAIL timeout_early: got done=%b busy=%b cnt=%0d, want 0 1 15", done_b, busy_b, cnt_b);
        end
        step();
        saw_valid |= vld_b;
        n_cmp++;
        if ({done_b, busy_b, err_b, cnt_b, saw_valid} !== {1'b1, 1'b0, 3'b010, 32'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout: got done=%b busy=%b err=%b cnt=%0d anyvalid=%b, want 1 0 010 16 0",
                     done_b, busy_b, err_b, cnt_b, saw_valid);
        end
    endtask

    task automatic test_errors();
        start_a = 1; step(); start_a = 0;
        aerr_a = 1; step(); aerr_a = 0;
        step();
        comp_a = 1; step(); comp_a = 0;
        n_cmp++;
        if ({cnt_a, err_a} !== {32'd3, 3'b001}) begin
            n_fail++;
            $display("FAIL err_run: got cnt=%0d err=%b, want 3 001", cnt_a, err_a);
        end
        rdy_a = 0; start_a = 1; step(); start_a = 0;
        drain_a(0, 4);
        n_cmp++;
        if ({done_a, err_a} !== {1'b1, 3'b101}) begin
            n_fail++;
            $display("FAIL err_flags: got done=%b err=%b, want 1 101", done_a, err_a);
        end
        start_a = 1; step(); start_a = 0;
        n_cmp++;
        if ({err_a, busy_a, cnt_a} !== {3'b000, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b cnt=%0d, want 000 1 0", err_a, busy_a, cnt_a);
        end
        comp_a = 1; step(); comp_a = 0;
        drain_a(0, 4);
    endtask

    task automatic test_reset_mid();
        run_a(2);
        drain_a(0, 2);
        RST = 1; step(); RST = 0;
        n_cmp++;
        if ({vld_a, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b busy=%b done=%b cnt=%0d, want 0 0 0 0",
                     vld_a, busy_a, done_a, cnt_a);
        end
        run_a(1);
        n_cmp++;
        if (cnt_a !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_rerun_cnt: got %0d want 1", cnt_a);
        end
        drain_a(0, 4);
        n_cmp++;
        if ({done_a, err_a} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_rerun_done: got done=%b err=%b, want 1 000", done_a, err_a);
        end
    endtask

    task automatic test_3x4();
        for (int e = 0; e < 12; e++) res_c[e*32 +: 32] = 32'(e);
        rdy_c = 1;
        start_c = 1; step(); start_c = 0;
        repeat (4) step();
        comp_c = 1; step(); comp_c = 0;
        n_cmp++;
        if (cnt_c !== 32'd5) begin
            n_fail++;
            $display("FAIL c_count: got %0d want 5", cnt_c);
        end
        for (int e = 0; e < 12; e++) begin
            n_cmp++;
            if ({vld_c, row_c, col_c, last_c, data_c} !== {1'b1, 2'(e / 4), 2'(e % 4), (e == 11), 32'(e)}) begin
                n_fail++;
                $display("FAIL c_beat %0d: got v=%b r=%0d c=%0d l=%b d=%h, want r=%0d c=%0d d=%h",
                         e, vld_c, row_c, col_c, last_c, data_c, e / 4, e % 4, e);
            end
            step();
        end
        n_cmp++;
        if ({done_c, vld_c, last_c} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL c_done: got done=%b v=%b l=%b, want 1 0 0", done_c, vld_c, last_c);
        end
    endtask

    initial begin
        exp_a[0] = 32'h3F800000;
        exp_a[1] = 32'h40000000;
        exp_a[2] = 32'h40400000;
        exp_a[3] = 32'h40800000;
        res_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        res_c = '0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_errors();
        test_reset_mid();
        test_3x4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
